// File: rtl/ysyx_25060170_lsu_if.sv
// ----------------------------------------------------------------------------
// ysyx_25060170_lsu_if
//   Bundles every handshake and bus signal of the load/store unit:
//     - EXU -> LSU op channel : in_valid/in_ready, in_addr, in_wdata,
//                               in_ren, in_wen, in_funct3
//     - LSU -> WBU result     : out_valid/out_ready, out_data, out_err
//     - LSU <-> memory bus    : mem_req, mem_we, mem_addr, mem_wdata,
//                               mem_wstrb, mem_gnt, mem_rvalid, mem_rdata,
//                               mem_rerr
//   Modports:
//     slave  : the LSU itself (consumes ops, drives results and bus requests)
//     master : the surrounding pipeline / bus model driving the LSU
// ----------------------------------------------------------------------------
interface ysyx_25060170_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_ren;
    logic        in_wen;
    logic [2:0]  in_funct3;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rerr;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_ren, in_wen, in_funct3,
        output in_ready,
        output out_valid, out_data, out_err,
        input  out_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_rerr
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_ren, in_wen, in_funct3,
        input  in_ready,
        input  out_valid, out_data, out_err,
        output out_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata, mem_rerr
    );
endinterface

// File: rtl/ysyx_25060170_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_25060170_lsu
//   Load/store unit between EXU and WBU. Accepts one op at a time, rejects
//   illegal or misaligned memory ops without touching the bus, issues a
//   single request/response bus access otherwise, formats load data, and
//   aborts any access that spends TIMEOUT cycles in REQ+WAIT.
//
//   Parameters:
//     TIMEOUT : max cycles in REQ+WAIT before abort (2..65535)
//   Ports:
//     clk   : single clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : ysyx_25060170_lsu_if.slave (op in, result out, memory bus)
// ----------------------------------------------------------------------------
module ysyx_25060170_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ysyx_25060170_lsu_if.slave        bus
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Op fields captured at accept time
    logic [31:0] r_addr;
    logic        r_wen;
    logic [2:0]  r_funct3;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic [15:0] r_tmo;
    logic [31:0] r_out_data;
    logic        r_out_err;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_bad;
    logic        w_f3_load_ok;
    logic        w_f3_store_ok;
    logic        w_misaligned;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_fmt;

    logic        w_tmo_clr;
    logic        w_tmo_inc;
    logic        w_out_load;
    logic [31:0] w_out_data_d;
    logic        w_out_err_d;

    // ------------------------------------------------------------------
    // Decode of the incoming op (valid only while presented in IDLE)
    // ------------------------------------------------------------------
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_is_mem = bus.in_ren || bus.in_wen;

    always_comb begin
        w_f3_load_ok  = 1'b0;
        w_f3_store_ok = 1'b0;
        case (bus.in_funct3)
            3'b000, 3'b001, 3'b010: begin
                w_f3_load_ok  = 1'b1;
                w_f3_store_ok = 1'b1;
            end
            3'b100, 3'b101: w_f3_load_ok = 1'b1;
            default: ;
        endcase
    end

    // funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        w_misaligned = 1'b0;
        case (bus.in_funct3[1:0])
            2'b01:   w_misaligned = bus.in_addr[0];
            2'b10:   w_misaligned = (bus.in_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_bad = (bus.in_ren && bus.in_wen)
                || (bus.in_ren && !w_f3_load_ok)
                || (bus.in_wen && !w_f3_store_ok)
                || w_misaligned;

    // Store lane strobes and replicated data; reads keep a zero strobe
    always_comb begin
        w_st_wstrb = '0;
        w_st_wdata = bus.in_wdata;
        case (bus.in_funct3[1:0])
            2'b00: begin
                w_st_wstrb = 4'b0001 << bus.in_addr[1:0];
                w_st_wdata = {4{bus.in_wdata[7:0]}};
            end
            2'b01: begin
                w_st_wstrb = bus.in_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{bus.in_wdata[15:0]}};
            end
            2'b10: w_st_wstrb = 4'b1111;
            default: w_st_wstrb = '0;
        endcase
        if (!bus.in_wen) begin
            w_st_wstrb = '0;
        end
    end

    // ------------------------------------------------------------------
    // Load formatting from the returned bus word
    // ------------------------------------------------------------------
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_ld_byte = bus.mem_rdata[7:0];
            2'b01:   w_ld_byte = bus.mem_rdata[15:8];
            2'b10:   w_ld_byte = bus.mem_rdata[23:16];
            default: w_ld_byte = bus.mem_rdata[31:24];
        endcase
    end

    assign w_ld_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_ld_fmt = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_fmt = {24'd0, w_ld_byte};
            3'b001:  w_ld_fmt = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_fmt = {16'd0, w_ld_half};
            3'b010:  w_ld_fmt = bus.mem_rdata;
            default: w_ld_fmt = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_tmo_clr    = 1'b0;
        w_tmo_inc    = 1'b0;
        w_out_load   = 1'b0;
        w_out_data_d = '0;
        w_out_err_d  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (!w_is_mem) begin
                        w_next       = S_DONE;
                        w_out_load   = 1'b1;
                        w_out_data_d = bus.in_addr;
                    end else if (w_bad) begin
                        w_next      = S_DONE;
                        w_out_load  = 1'b1;
                        w_out_err_d = 1'b1;
                    end else begin
                        w_next    = S_REQ;
                        w_tmo_clr = 1'b1;
                    end
                end
            end

            // The timeout check wins over a grant in the same cycle, so
            // the request never outlives its cycle budget.
            S_REQ: begin
                if (r_tmo == TMO_LAST) begin
                    w_next      = S_DONE;
                    w_out_load  = 1'b1;
                    w_out_err_d = 1'b1;
                end else begin
                    w_tmo_inc = 1'b1;
                    if (bus.mem_gnt) begin
                        w_next = S_WAIT;
                    end
                end
            end

            // A response in the last allowed cycle still completes.
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_next      = S_DONE;
                    w_out_load  = 1'b1;
                    w_out_err_d = bus.mem_rerr;
                    if (!bus.mem_rerr && !r_wen) begin
                        w_out_data_d = w_ld_fmt;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_next      = S_DONE;
                    w_out_load  = 1'b1;
                    w_out_err_d = 1'b1;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end

            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_funct3    <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_tmo       <= '0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_addr      <= bus.in_addr;
                r_wen       <= bus.in_wen;
                r_funct3    <= bus.in_funct3;
                r_mem_wdata <= w_st_wdata;
                r_mem_wstrb <= w_st_wstrb;
            end

            if (w_tmo_clr) begin
                r_tmo <= '0;
            end else if (w_tmo_inc) begin
                r_tmo <= r_tmo + 16'd1;
            end

            if (w_out_load) begin
                r_out_data <= w_out_data_d;
                r_out_err  <= w_out_err_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_data  = r_out_data;
    assign bus.out_err   = r_out_err;

    assign bus.mem_req   = (r_state == S_REQ);
    assign bus.mem_we    = r_wen;
    assign bus.mem_addr  = {r_addr[31:2], 2'b00};
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25060170_lsu
//   Drives directed and random ops into the LSU with a small TIMEOUT, and
//   compares every cycle against expectations derived from a transaction
//   level model of the access rules (legality, lane strobes, load
//   formatting, cycle budget).
// ----------------------------------------------------------------------------
module tb_ysyx_25060170_lsu;

    localparam int unsigned TMO = 4;

    logic clk;
    logic rst_n;

    ysyx_25060170_lsu_if bus_if ();

    ysyx_25060170_lsu #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    // Expected outputs for the current cycle, set by the driver
    logic        chk_en = 1'b0;
    logic        e_in_ready, e_out_valid, e_mem_req;
    logic [31:0] e_out_data;
    logic        e_out_err;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_strb;

    // Last values observed by the compare process, used by literal checks
    logic [31:0] last_data, last_addr, last_wdata;
    logic        last_err;
    logic [3:0]  last_strb;
    int unsigned bus_cycles;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic void predict(input logic ren, input logic wen,
                                    input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wd,
                                    output logic bus_op, output logic err,
                                    output logic [3:0] strb, output logic [31:0] mwd);
        int unsigned nb;
        logic legal;
        nb   = 1 << f3[1:0];
        strb = '0;
        mwd  = wd;
        if (!ren && !wen) begin
            bus_op = 1'b0;
            err    = 1'b0;
            return;
        end
        if (ren && wen)  legal = 1'b0;
        else if (ren)    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else             legal = (f3 inside {3'd0, 3'd1, 3'd2});
        if (legal && (addr % nb) != 0) legal = 1'b0;
        bus_op = legal;
        err    = !legal;
        if (wen && legal) begin
            strb = 4'(((1 << nb) - 1) << (addr % 4));
            for (int unsigned i = 0; i < 4; i++)
                mwd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned nb;
        logic [31:0] mask, v;
        nb = 1 << f3[1:0];
        if (nb == 4) return rdata;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = (rdata >> (8 * (addr % 4))) & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle compare
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  {31'd0, bus_if.in_ready},  {31'd0, e_in_ready});
            chk("out_valid", {31'd0, bus_if.out_valid}, {31'd0, e_out_valid});
            chk("mem_req",   {31'd0, bus_if.mem_req},   {31'd0, e_mem_req});
            if (e_out_valid) begin
                chk("out_data", bus_if.out_data, e_out_data);
                chk("out_err",  {31'd0, bus_if.out_err}, {31'd0, e_out_err});
                last_data = bus_if.out_data;
                last_err  = bus_if.out_err;
            end
            if (e_mem_req) begin
                chk("mem_addr",  bus_if.mem_addr, e_addr);
                chk("mem_we",    {31'd0, bus_if.mem_we}, {31'd0, e_we});
                chk("mem_wstrb", {28'd0, bus_if.mem_wstrb}, {28'd0, e_strb});
                if (e_we) chk("mem_wdata", bus_if.mem_wdata, e_wdata);
                last_addr  = bus_if.mem_addr;
                last_strb  = bus_if.mem_wstrb;
                last_wdata = bus_if.mem_wdata;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_last();
        last_data  = 'x;
        last_err   = 1'bx;
        last_addr  = 'x;
        last_strb  = 'x;
        last_wdata = 'x;
    endtask

    task automatic idle(input int unsigned n, input logic force_rv);
        for (int unsigned c = 0; c < n; c++) begin
            bus_if.in_valid   = 1'b0;
            bus_if.mem_gnt    = 1'($urandom % 2);
            bus_if.mem_rvalid = force_rv ? 1'b1 : 1'($urandom % 2);
            bus_if.mem_rdata  = $urandom;
            e_in_ready  = 1'b1;
            e_out_valid = 1'b0;
            e_mem_req   = 1'b0;
            step();
        end
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_gnt    = 1'b0;
    endtask

    // One complete op: present, bus phase (if any), result held for rdy cycles
    task automatic run_op(input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd_data, input logic rerr,
                          input int unsigned gd, input int unsigned rdl,
                          input int unsigned rdy);
        logic        bus_op, err, granted, fin;
        logic [3:0]  strb;
        logic [31:0] mwd, data;
        int unsigned k, rv_at;

        predict(ren, wen, f3, addr, wd, bus_op, err, strb, mwd);
        data = (!ren && !wen) ? addr : 32'd0;

        bus_if.in_valid   = 1'b1;
        bus_if.in_ren     = ren;
        bus_if.in_wen     = wen;
        bus_if.in_funct3  = f3;
        bus_if.in_addr    = addr;
        bus_if.in_wdata   = wd;
        bus_if.mem_gnt    = 1'($urandom % 2);
        bus_if.mem_rvalid = 1'($urandom % 2);
        e_in_ready  = 1'b1;
        e_out_valid = 1'b0;
        e_mem_req   = 1'b0;
        step();

        // Op fields must have been captured; scramble the inputs
        bus_if.in_valid  = 1'b0;
        bus_if.in_ren    = 1'($urandom % 2);
        bus_if.in_wen    = 1'($urandom % 2);
        bus_if.in_funct3 = 3'($urandom % 8);
        bus_if.in_addr   = $urandom;
        bus_if.in_wdata  = $urandom;
        bus_cycles = 0;

        if (bus_op) begin
            granted = 1'b0;
            fin     = 1'b0;
            k       = 0;
            rv_at   = 0;
            e_addr  = addr & ~32'd3;
            e_we    = wen;
            e_strb  = strb;
            e_wdata = mwd;
            while (!fin) begin
                e_in_ready  = 1'b0;
                e_out_valid = 1'b0;
                e_mem_req   = !granted;
                if (!granted) begin
                    bus_if.mem_gnt    = (k == gd);
                    bus_if.mem_rvalid = 1'($urandom % 2);
                    bus_if.mem_rdata  = $urandom;
                    bus_if.mem_rerr   = 1'($urandom % 2);
                end else begin
                    bus_if.mem_gnt    = 1'($urandom % 2);
                    bus_if.mem_rvalid = (k == rv_at);
                    bus_if.mem_rdata  = rd_data;
                    bus_if.mem_rerr   = rerr;
                end
                if (granted && k == rv_at) begin
                    fin  = 1'b1;
                    err  = rerr;
                    data = (rerr || wen) ? 32'd0 : load_fmt(f3, addr, rd_data);
                end else if (k == TMO - 1) begin
                    fin  = 1'b1;
                    err  = 1'b1;
                    data = 32'd0;
                end else if (!granted && k == gd) begin
                    granted = 1'b1;
                    rv_at   = k + 1 + rdl;
                end
                step();
                k++;
            end
            bus_cycles = k;
        end

        e_out_data = data;
        e_out_err  = err;
        for (int unsigned c = 0; c <= rdy; c++) begin
            e_in_ready        = 1'b0;
            e_out_valid       = 1'b1;
            e_mem_req         = 1'b0;
            bus_if.out_ready  = (c == rdy);
            bus_if.mem_gnt    = 1'($urandom % 2);
            bus_if.mem_rvalid = 1'($urandom % 2);
            bus_if.mem_rdata  = $urandom;
            bus_if.mem_rerr   = 1'($urandom % 2);
            step();
        end
        bus_if.out_ready  = 1'b0;
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_gnt    = 1'b0;
        e_in_ready  = 1'b1;
        e_out_valid = 1'b0;
        e_mem_req   = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic        ren, wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        int unsigned sel, nb;
        logic [2:0]  ld_f3 [5];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst_n             = 1'b0;
        bus_if.in_valid   = 1'b0;
        bus_if.in_ren     = 1'b0;
        bus_if.in_wen     = 1'b0;
        bus_if.in_funct3  = '0;
        bus_if.in_addr    = '0;
        bus_if.in_wdata   = '0;
        bus_if.out_ready  = 1'b0;
        bus_if.mem_gnt    = 1'b0;
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = '0;
        bus_if.mem_rerr   = 1'b0;
        e_in_ready  = 1'b1;
        e_out_valid = 1'b0;
        e_mem_req   = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("rst_mem_req",   {31'd0, bus_if.mem_req},   32'd0);
        chk("rst_out_data",  bus_if.out_data,  32'd0);
        chk("rst_mem_addr",  bus_if.mem_addr,  32'd0);
        chk("rst_mem_wstrb", {28'd0, bus_if.mem_wstrb}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_en = 1'b1;

        // Model pins against hand-computed values
        chk("model_lb",  load_fmt(3'd0, 32'h80000003, 32'h80FF7F01), 32'hFFFFFF80);
        chk("model_lhu", load_fmt(3'd5, 32'h00000002, 32'h80FF7F01), 32'h000080FF);

        // Pass-through
        clear_last();
        run_op(1'b0, 1'b0, 3'd0, 32'h12345678, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        chk("pt_data", last_data, 32'h12345678);
        chk("pt_err",  {31'd0, last_err}, 32'd0);

        // LB / LBU sign handling
        clear_last();
        run_op(1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FF7F01, 1'b0, 0, 0, 0);
        chk("lb_addr", last_addr, 32'h80000000);
        chk("lb_data", last_data, 32'hFFFFFF80);
        chk("lb_cycles", bus_cycles, 32'd2);
        clear_last();
        run_op(1'b1, 1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80FF7F01, 1'b0, 0, 0, 0);
        chk("lbu_data", last_data, 32'h00000080);

        // SH upper half
        clear_last();
        run_op(1'b0, 1'b1, 3'b001, 32'h80000002, 32'hDEADBEEF, 32'h5555AAAA, 1'b0, 1, 1, 0);
        chk("sh_strb",  {28'd0, last_strb}, 32'h0000000C);
        chk("sh_wdata", last_wdata, 32'hBEEFBEEF);
        chk("sh_data",  last_data, 32'd0);

        // Misaligned LW
        clear_last();
        run_op(1'b1, 1'b0, 3'b010, 32'h80000001, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        chk("mis_err",  {31'd0, last_err}, 32'd1);
        chk("mis_data", last_data, 32'd0);

        // Timeout, late response ignored, then a normal op
        clear_last();
        run_op(1'b1, 1'b0, 3'b010, 32'h80000010, 32'h0, 32'h0, 1'b0, 0, 100, 0);
        chk("tmo_err",    {31'd0, last_err}, 32'd1);
        chk("tmo_cycles", bus_cycles, TMO);
        idle(2, 1'b1);
        clear_last();
        run_op(1'b1, 1'b0, 3'b010, 32'h80000010, 32'h0, 32'hCAFEF00D, 1'b0, 0, 0, 0);
        chk("post_tmo_data", last_data, 32'hCAFEF00D);
        chk("post_tmo_err",  {31'd0, last_err}, 32'd0);

        // Backpressure: held across 5 stalled cycles
        run_op(1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0, 32'h8001_7FFF, 1'b0, 0, 0, 5);
        chk("bp_data", last_data, 32'hFFFF8001);

        // Reset pulsed in WAIT of a store
        chk_en = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in_ren    = 1'b0;
        bus_if.in_wen    = 1'b1;
        bus_if.in_funct3 = 3'b010;
        bus_if.in_addr   = 32'h0000_0040;
        bus_if.in_wdata  = 32'h1234_5678;
        step();
        bus_if.in_valid = 1'b0;
        bus_if.mem_gnt  = 1'b1;
        step();
        bus_if.mem_gnt  = 1'b0;
        chk("pre_rst_we", {31'd0, bus_if.mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("arst_mem_req",   {31'd0, bus_if.mem_req},   32'd0);
        chk("arst_out_data",  bus_if.out_data,  32'd0);
        chk("arst_out_err",   {31'd0, bus_if.out_err},   32'd0);
        chk("arst_mem_we",    {31'd0, bus_if.mem_we},    32'd0);
        chk("arst_mem_wstrb", {28'd0, bus_if.mem_wstrb}, 32'd0);
        chk("arst_mem_addr",  bus_if.mem_addr,  32'd0);
        chk("arst_mem_wdata", bus_if.mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        chk_en = 1'b1;
        idle(2, 1'b1);

        // Random ops
        for (int unsigned n = 0; n < 300; n++) begin
            sel = $urandom % 8;
            ren = (sel >= 1 && sel <= 4);
            wen = (sel == 1) || (sel >= 5);
            if ($urandom % 5 == 0)  f3 = 3'($urandom % 8);
            else if (ren)           f3 = ld_f3[$urandom % 5];
            else                    f3 = 3'($urandom % 3);
            nb   = 1 << f3[1:0];
            addr = $urandom;
            if ($urandom % 4 != 0) addr = addr & ~(nb - 1);
            run_op(ren, wen, f3, addr, $urandom, $urandom, 1'(($urandom % 8) == 0),
                   $urandom % 5, $urandom % 5, $urandom % 4);
            if ($urandom % 4 == 0) idle($urandom % 3, 1'b0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_25060170_lsu.md
YSYX_25060170_LSU -- requirements
Module: ysyx_25060170_LSU

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum number of cycles spent in REQ+WAIT before an access is aborted; legal range 2..65535.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  in  1  EXU result valid.
REQ-005 in_ready  out  1  LSU can accept a new op.
REQ-006 in_addr  in  32  EXU result: effective address, or the ALU result for non-memory ops.
REQ-007 in_wdata  in  32  store data (rs2).
REQ-008 in_ren  in  1  load op.
REQ-009 in_wen  in  1  store op.
REQ-010 in_funct3  in  3  access size/sign.
REQ-011 out_valid  out  1  result valid to WBU.
REQ-012 out_ready  in  1  WBU accepts the result.
REQ-013 out_data  out  32  writeback value.
REQ-014 out_err  out  1  access fault: misaligned, illegal, bus error or timeout.
REQ-015 mem_req  out  1  bus request.
REQ-016 mem_we  out  1  1 = write.
REQ-017 mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_wstrb  out  4  byte enables; 0 for reads.
REQ-020 mem_gnt  in  1  bus accepted the request this cycle.
REQ-021 mem_rvalid  in  1  read data or write ack valid.
REQ-022 mem_rdata  in  32  read data.
REQ-023 mem_rerr  in  1  bus error, qualified by mem_rvalid.

Function
REQ-024 FSM states SHALL be IDLE, REQ, WAIT and DONE; in_ready=1 only in IDLE; mem_req=1 only in REQ; out_valid=1 only in DONE.
REQ-025 In IDLE, in_valid=1 SHALL latch every in_* signal. With in_ren=in_wen=0 the FSM goes to DONE, out_data=in_addr, out_err=0.
REQ-026 A memory op SHALL go directly to DONE with out_err=1, out_data=0 and no bus request if any of these holds:
- in_ren and in_wen are both 1;
- funct3 is not in {000,001,010,100,101} for a load;
- funct3 is not in {000,001,010} for a store;
- the access is misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-027 Otherwise the FSM SHALL go to REQ and clear the timeout counter.
REQ-028 In REQ, mem_we/mem_addr/mem_wdata/mem_wstrb SHALL be stable. mem_gnt=1 moves the FSM to WAIT; mem_rvalid is ignored in REQ.
REQ-029 Store strobes and data:
- SB: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}};
- SH: wstrb=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}};
- SW: wstrb=4'b1111.
REQ-030 In WAIT, mem_rvalid=1 SHALL move the FSM to DONE with out_err=mem_rerr. out_data is 0 for stores and on error; otherwise it is the formatted load.
REQ-031 Load formatting SHALL select the byte by addr[1:0] or the halfword by addr[1], then:
- LB/LH sign-extend to 32 bits;
- LBU/LHU zero-extend to 32 bits;
- LW passes the word unchanged.
REQ-032 The timeout counter SHALL increment every cycle in REQ or WAIT. When it reaches TIMEOUT-1 without completion, the FSM goes to DONE with out_err=1, out_data=0, and mem_req drops that same edge.
REQ-033 After a timeout abort, a late mem_rvalid SHALL be ignored, as SHALL any mem_rvalid seen in IDLE or DONE.
REQ-034 In DONE, out_data/out_err SHALL hold until out_ready=1, then the FSM returns to IDLE. No new op is accepted in the same cycle; minimum spacing is 2 cycles per op.
REQ-035 Latency, with accept at edge N:
- non-memory op: out_valid from N+1;
- memory op with gnt at N+1 and rvalid at N+2: out_valid from N+3.

Reset
REQ-036 With rst_n=0, the FSM SHALL be IDLE immediately and asynchronously, with out_valid=0, mem_req=0, out_data=0, out_err=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0 and the timeout counter at 0.
REQ-037 Reset asserted mid-access SHALL abandon the transaction with no out_valid. A bus response arriving after reset release is ignored per REQ-033.
REQ-038 in_ready SHALL read 1 from the first cycle after rst_n deasserts.

Verification
REQ-039 Pass-through: in_addr=0x12345678, ren=wen=0, out_ready=1 -> out_valid at N+1, out_data=0x12345678, out_err=0, mem_req never 1.
REQ-040 LB sign: addr=0x80000003, mem_rdata=0x80FF7F01, gnt and rvalid immediate -> mem_addr=0x80000000, out_data=0xFFFFFF80. The same access with LBU -> 0x00000080.
REQ-041 SH: addr=0x80000002, wdata=0xDEADBEEF -> mem_wstrb=4'b1100, mem_wdata=0xBEEFBEEF, mem_we=1. out_data=0 after the ack.
REQ-042 Misaligned LW at addr=0x80000001 -> DONE next cycle with out_err=1, mem_req never asserted.
REQ-043 Timeout with TIMEOUT=4, gnt=1, rvalid never -> out_err=1 after 4 cycles in REQ+WAIT. A later rvalid is ignored, and the next op completes normally.
REQ-044 Backpressure and reset: with out_ready=0 for 5 cycles, out_data is held stable. With rst_n pulsed low in WAIT, outputs are 0 immediately and in_ready=1 after release.
